// File: rtl/reg_select_sequencer_pkg.sv
// Shared definitions for the MERC-16 register-select sequencer: state
// encodings, select-phase codes, instruction field positions, NOP opcode.
package reg_select_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ_A = 3'd1,
    ST_READ_B = 3'd2,
    ST_WAIT   = 3'd3,
    ST_WRITE  = 3'd4
  } state_t;

  localparam logic [1:0] PH_NONE  = 2'd0;
  localparam logic [1:0] PH_READA = 2'd1;
  localparam logic [1:0] PH_READB = 2'd2;
  localparam logic [1:0] PH_WRITE = 2'd3;

  localparam int OP_WIDTH   = 4;
  localparam int FLD_RD_LSB = 8;
  localparam int FLD_RS_LSB = 4;
  localparam int FLD_RT_LSB = 0;

  localparam logic [OP_WIDTH-1:0] NOP_OPCODE = 4'h0;

endpackage

// File: rtl/reg_select_sequencer_wait_timer.sv
// Writeback wait timer. Loaded on WAIT entry and counted down once per WAIT
// cycle; Expired marks the last permitted WAIT cycle (cycle TIMEOUT).
module wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic Clear,
  input  logic Enable,
  output logic Expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Down-counter: reload on Clear, decrement while enabled, stop at zero.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      count <= '0;
    end else if (Clear) begin
      count <= LOAD;
    end else if (Enable && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign Expired = (count == '0);

endmodule

// File: rtl/reg_select_sequencer.sv
// Register-select sequencer feeding the Decoder index of the MERC-16
// datapath: accepts one instruction per handshake, then walks read Rs,
// read Rt and (after the ALU result) write Rd, aborting stalled writebacks.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_IDLE   | ready for a new instruction; NOPs are consumed here
//   ST_READ_A | SelIdx = Rs, phase 1
//   ST_READ_B | SelIdx = Rt, phase 2; wait timer loads on exit
//   ST_WAIT   | waiting for ResultValid, bounded by the wait timer
//   ST_WRITE  | SelIdx = Rd, phase 3, write strobe unless Rd is R0
module reg_select_sequencer
  import reg_select_sequencer_pkg::*;
#(
  parameter int                   N       = 4,
  parameter int                   W       = 16,
  parameter int                   TIMEOUT = 15,
  parameter logic [OP_WIDTH-1:0]  NOP_OP  = NOP_OPCODE
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                InValid,
  output logic                InReady,
  input  logic [W-1:0]        InInstr,
  input  logic                ResultValid,
  output logic [N-1:0]        SelIdx,
  output logic                SelEn,
  output logic [1:0]          SelPhase,
  output logic                WriteEn,
  output logic [OP_WIDTH-1:0] OpOut,
  output logic                Error
);

  state_t              state;
  logic [N-1:0]        rd_q;
  logic [N-1:0]        rt_q;
  logic [OP_WIDTH-1:0] op_in;
  logic [N-1:0]        rd_in;
  logic [N-1:0]        rs_in;
  logic [N-1:0]        rt_in;
  logic                accept;
  logic                tmr_clear;
  logic                tmr_en;
  logic                tmr_expired;

  assign op_in  = InInstr[W-1 -: OP_WIDTH];
  assign rd_in  = InInstr[FLD_RD_LSB +: N];
  assign rs_in  = InInstr[FLD_RS_LSB +: N];
  assign rt_in  = InInstr[FLD_RT_LSB +: N];
  assign accept = InValid & InReady;

  // The timer loads on the READ_B -> WAIT edge and runs only while waiting.
  assign tmr_clear = (state == ST_READ_B);
  assign tmr_en    = (state == ST_WAIT);

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .Clear   (tmr_clear),
    .Enable  (tmr_en),
    .Expired (tmr_expired)
  );

  // Sequencer FSM with field latch; outputs are registered for the state being entered.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= ST_IDLE;
      rd_q     <= '0;
      rt_q     <= '0;
      InReady  <= 1'b0;
      SelIdx   <= '0;
      SelEn    <= 1'b0;
      SelPhase <= PH_NONE;
      WriteEn  <= 1'b0;
      OpOut    <= '0;
      Error    <= 1'b0;
    end else begin
      WriteEn <= 1'b0;
      Error   <= 1'b0;
      case (state)
        ST_IDLE: begin
          InReady <= 1'b1;
          if (accept) begin
            OpOut <= op_in;
            rd_q  <= rd_in;
            rt_q  <= rt_in;
            if (op_in != NOP_OP) begin
              state    <= ST_READ_A;
              InReady  <= 1'b0;
              SelIdx   <= rs_in;
              SelEn    <= 1'b1;
              SelPhase <= PH_READA;
            end
          end
        end
        ST_READ_A: begin
          state    <= ST_READ_B;
          SelIdx   <= rt_q;
          SelEn    <= 1'b1;
          SelPhase <= PH_READB;
        end
        ST_READ_B: begin
          state    <= ST_WAIT;
          SelIdx   <= '0;
          SelEn    <= 1'b0;
          SelPhase <= PH_NONE;
        end
        ST_WAIT: begin
          // A result arriving on the last permitted cycle still wins over the abort.
          if (ResultValid) begin
            state    <= ST_WRITE;
            SelIdx   <= rd_q;
            SelEn    <= (rd_q != '0);
            SelPhase <= PH_WRITE;
            WriteEn  <= (rd_q != '0);
          end else if (tmr_expired) begin
            state   <= ST_IDLE;
            InReady <= 1'b1;
            Error   <= 1'b1;
          end
        end
        ST_WRITE: begin
          state    <= ST_IDLE;
          InReady  <= 1'b1;
          SelIdx   <= '0;
          SelEn    <= 1'b0;
          SelPhase <= PH_NONE;
        end
        default: begin
          state    <= ST_IDLE;
          InReady  <= 1'b0;
          SelIdx   <= '0;
          SelEn    <= 1'b0;
          SelPhase <= PH_NONE;
        end
      endcase
    end
  end

endmodule
